prbs_burst_ctrl: RTL and testbench
==================================

// Module: prbs_burst_ctrl
// PURPOSE
//  Sequencer for the PRBS LFSR engine. Latches a burst configuration on start,
//  loads the LFSR seed and polynomial, then gates LFSR stepping into bursts of
//  cfg_len bits separated by cfg_gap idle cycles, for cfg_reps bursts or
//  continuously. Sits between the user-pin command decode and the LFSR core.
// PARAMETERS
//  SEED_W  31  seed width; covers PRBS31, the widest supported polynomial
//  LEN_W   8   burst-length counter width
//  GAP_W   4   gap-length counter width
//  REP_W   4   repeat counter width
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       synchronous active-low reset
//  ena        in   1       0 = freeze FSM and counters; forces lfsr_step=0
//  start      in   1       request a run; sampled only in IDLE
//  stop       in   1       abort the run; sampled in any non-IDLE state
//  cfg_poly   in   2       polynomial: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
//  cfg_seed   in   SEED_W  initial LFSR state
//  cfg_len    in   LEN_W   bits per burst; 1..2^LEN_W-1
//  cfg_gap    in   GAP_W   idle cycles between bursts; 0 = bursts back to back
//  cfg_reps   in   REP_W   number of bursts; 0 = continuous until stop
//  lfsr_load  out  1       1-cycle pulse: LFSR loads lfsr_seed
//  lfsr_seed  out  SEED_W  masked, non-zero seed
//  lfsr_poly  out  2       latched polynomial select
//  lfsr_step  out  1       LFSR advances one bit when high
//  busy       out  1       high when state != IDLE
//  done       out  1       1-cycle pulse on normal completion
//  err        out  1       1-cycle pulse when start is rejected
// BEHAVIOUR
//  - Reset: state=IDLE. All counters 0. lfsr_load, lfsr_step, busy, done and err are 0.
//    lfsr_seed and lfsr_poly are 0. Reset mid-run takes effect at the next edge.
//  - States: IDLE, LOAD, RUN, GAP, DONE. Outputs decode the registered state.
//    lfsr_step = (state==RUN) & ena. lfsr_load = (state==LOAD).
//  - IDLE: when start=1, stop=0, ena=1 and cfg_len!=0, all cfg_* inputs are latched
//    and the next state is LOAD. If cfg_len==0, err pulses in the next cycle and the
//    state stays IDLE. If start and stop are both 1, nothing happens.
//  - Seed: the latched seed is masked to the polynomial width (7/15/23/31 bits).
//    If the masked value is 0, it is replaced with 1.
//  - LOAD: lasts 1 cycle, then RUN. First lfsr_step is 2 cycles after the start edge.
//  - RUN: lfsr_step stays high for exactly cfg_len ena-qualified cycles.
//    When the burst ends and it was the last burst (reps finite), go to DONE.
//    Otherwise go to GAP, or straight to RUN if cfg_gap==0.
//    The LFSR is not reloaded between bursts; the sequence continues.
//  - GAP: cfg_gap cycles with lfsr_step=0, then RUN.
//  - DONE: done=1 for 1 cycle, then IDLE.
//  - stop=1 in LOAD, RUN or GAP: next state is IDLE, no done pulse.
//    stop has priority over every other transition in that cycle.
//  - ena=0: state and all counters hold; lfsr_step=0; lfsr_load, done and err are
//    held off and resume when ena returns. Total steps per burst stay exactly cfg_len.
//  - start while busy is ignored; cfg_* changes mid-run have no effect.
// TESTING
//  1. poly=0, seed=0x55, len=4, gap=2, reps=2, start at edge 0 -> load in cycle 1;
//     step in cycles 2-5 and 8-11; done in cycle 12; busy in cycles 1-12.
//  2. poly=3, seed=0 -> lfsr_seed=0x00000001 during LOAD.
//     poly=0, seed=0x7FFFFFFF -> lfsr_seed=0x7F.
//  3. len=0 with start -> err=1 for 1 cycle; busy, lfsr_load and lfsr_step stay 0.
//  4. len=3, gap=0, reps=0 -> step high continuously from cycle 2; stop at cycle 20
//     -> step=0 and busy=0 from cycle 21; done never asserts.
//  5. len=8, reps=1, ena=0 for 3 cycles mid-RUN -> step low in those cycles;
//     total step count = 8; done pulses 3 cycles later than without the stall.
//  6. rst_n=0 during RUN -> all outputs 0 at the next edge; a new start after
//     reset runs normally, and start while busy is ignored.

Source files
------------

// File: rtl/prbs_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : prbs_burst_ctrl_if
// Description : Command / LFSR-control bundle for the PRBS burst sequencer.
//               master : command decode side (drives ena, start, stop, cfg_*;
//                        observes lfsr_*, busy, done, err)
//               slave  : prbs_burst_ctrl (the opposite directions)
//               Signals:
//                 ena, start, stop          run control
//                 cfg_poly/seed/len/gap/reps burst configuration
//                 lfsr_load/seed/poly/step  LFSR core control
//                 busy, done, err           status
// Revision    : 1.0 - initial release
// ============================================================================
interface prbs_burst_ctrl_if #(
  parameter int SEED_W = 31,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4,
  parameter int REP_W  = 4
);
  logic              ena;
  logic              start;
  logic              stop;
  logic [1:0]        cfg_poly;
  logic [SEED_W-1:0] cfg_seed;
  logic [LEN_W-1:0]  cfg_len;
  logic [GAP_W-1:0]  cfg_gap;
  logic [REP_W-1:0]  cfg_reps;
  logic              lfsr_load;
  logic [SEED_W-1:0] lfsr_seed;
  logic [1:0]        lfsr_poly;
  logic              lfsr_step;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output ena, start, stop, cfg_poly, cfg_seed, cfg_len, cfg_gap, cfg_reps,
    input  lfsr_load, lfsr_seed, lfsr_poly, lfsr_step, busy, done, err
  );

  modport slave (
    input  ena, start, stop, cfg_poly, cfg_seed, cfg_len, cfg_gap, cfg_reps,
    output lfsr_load, lfsr_seed, lfsr_poly, lfsr_step, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prbs_burst_ctrl
// Description : Sequencer for the PRBS LFSR engine. Latches a burst config on
//               start, loads the (masked, non-zero) seed and polynomial, then
//               gates LFSR stepping into bursts of cfg_len bits separated by
//               cfg_gap idle cycles, for cfg_reps bursts (0 = continuous).
// Ports       : clk   - system clock
//               rst_n - synchronous active-low reset
//               bus   - prbs_burst_ctrl_if.slave (run control, config,
//                       LFSR control outputs, busy/done/err status)
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_burst_ctrl #(
  parameter int SEED_W = 31,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4,
  parameter int REP_W  = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  prbs_burst_ctrl_if.slave    bus
);

  // Seed masks for PRBS7 / PRBS15 / PRBS23 / PRBS31.
  localparam logic [SEED_W-1:0] c_mask7  = SEED_W'(64'h0000_007F);
  localparam logic [SEED_W-1:0] c_mask15 = SEED_W'(64'h0000_7FFF);
  localparam logic [SEED_W-1:0] c_mask23 = SEED_W'(64'h007F_FFFF);
  localparam logic [SEED_W-1:0] c_mask31 = SEED_W'(64'h7FFF_FFFF);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [GAP_W-1:0]  r_gap;
  logic [REP_W-1:0]  r_reps;
  logic [LEN_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [SEED_W-1:0] r_seed;
  logic [1:0]        r_poly;
  logic              r_err;

  logic [SEED_W-1:0] w_mask;
  logic [SEED_W-1:0] w_seed_masked;
  logic [SEED_W-1:0] w_seed_fixed;
  logic              w_accept;
  logic              w_reject;
  logic              w_burst_end;
  logic              w_last_burst;
  logic              w_gap_end;

  always_comb begin
    w_mask = c_mask31;
    case (bus.cfg_poly)
      2'd0:    w_mask = c_mask7;
      2'd1:    w_mask = c_mask15;
      2'd2:    w_mask = c_mask23;
      default: w_mask = c_mask31;
    endcase
  end

  // An all-zero LFSR state is a lock-up state, so substitute 1.
  assign w_seed_masked = bus.cfg_seed & w_mask;
  assign w_seed_fixed  = (w_seed_masked == '0) ? SEED_W'(1) : w_seed_masked;

  assign w_accept     = bus.start & ~bus.stop & (bus.cfg_len != '0);
  assign w_reject     = bus.start & ~bus.stop & (bus.cfg_len == '0);
  assign w_burst_end  = (r_bit_cnt == r_len - LEN_W'(1));
  // reps == 0 means continuous, so no burst is ever the last one.
  assign w_last_burst = (r_reps != '0) && (r_rep_cnt == r_reps - REP_W'(1));
  assign w_gap_end    = (r_gap_cnt == r_gap - GAP_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_gap     <= '0;
      r_reps    <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rep_cnt <= '0;
      r_seed    <= '0;
      r_poly    <= '0;
      r_err     <= 1'b0;
    end else if (bus.ena) begin
      // With ena low everything, including a pending err, simply holds.
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len     <= bus.cfg_len;
            r_gap     <= bus.cfg_gap;
            r_reps    <= bus.cfg_reps;
            r_seed    <= w_seed_fixed;
            r_poly    <= bus.cfg_poly;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_rep_cnt <= '0;
            r_state   <= S_LOAD;
          end else if (w_reject) begin
            r_err <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= bus.stop ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else if (w_burst_end) begin
            r_bit_cnt <= '0;
            if (w_last_burst) begin
              r_state <= S_DONE;
            end else begin
              r_rep_cnt <= r_rep_cnt + REP_W'(1);
              r_gap_cnt <= '0;
              r_state   <= (r_gap == '0) ? S_RUN : S_GAP;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + LEN_W'(1);
          end
        end
        S_GAP: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else if (w_gap_end) begin
            r_state <= S_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.lfsr_step = (r_state == S_RUN)  & bus.ena;
  assign bus.lfsr_load = (r_state == S_LOAD) & bus.ena;
  assign bus.done      = (r_state == S_DONE) & bus.ena;
  assign bus.err       = r_err & bus.ena;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.lfsr_seed = r_seed;
  assign bus.lfsr_poly = r_poly;

endmodule
`default_nettype wire

// File: tb/tb_prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_burst_ctrl
// Description : Directed self-checking bench for prbs_burst_ctrl. Cycle n is
//               the interval after clock edge n-1; start is applied in cycle 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_burst_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  prbs_burst_ctrl_if #(.SEED_W(31), .LEN_W(8), .GAP_W(4), .REP_W(4)) bus ();

  prbs_burst_ctrl #(.SEED_W(31), .LEN_W(8), .GAP_W(4), .REP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Status vector {err, load, step, busy, done}.
  function automatic logic [31:0] obs();
    return {27'd0, bus.err, bus.lfsr_load, bus.lfsr_step, bus.busy, bus.done};
  endfunction

  function automatic logic [31:0] ex(input bit e, input bit l, input bit s,
                                     input bit b, input bit d);
    return {27'd0, e, l, s, b, d};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] p, input logic [30:0] s, input logic [7:0] l,
                         input logic [3:0] g, input logic [3:0] r);
    bus.cfg_poly = p;
    bus.cfg_seed = s;
    bus.cfg_len  = l;
    bus.cfg_gap  = g;
    bus.cfg_reps = r;
  endtask

  // Start a run, abort it in LOAD with stop, and check the seed presented.
  task automatic seed_case(input string tag, input logic [1:0] p, input logic [30:0] s,
                           input logic [31:0] exp_seed);
    set_cfg(p, s, 8'd1, 4'd0, 4'd1);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    sample();
    chk({tag, " load"}, obs(), ex(0, 1, 0, 1, 0));
    chk({tag, " seed"}, {1'b0, bus.lfsr_seed}, exp_seed);
    chk({tag, " poly"}, {30'd0, bus.lfsr_poly}, {30'd0, p});
    next_cyc();
    bus.stop = 1'b0;
    sample();
    chk({tag, " stopped"}, obs(), ex(0, 0, 0, 0, 0));
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(2'd0, 31'd0, 8'd0, 4'd0, 4'd0);
    repeat (3) next_cyc();
    sample();
    chk("reset status", obs(), ex(0, 0, 0, 0, 0));
    chk("reset seed", {1'b0, bus.lfsr_seed}, 32'd0);
    chk("reset poly", {30'd0, bus.lfsr_poly}, 32'd0);
    rst_n = 1'b1;
    next_cyc();

    // 1: two bursts of 4 with gap 2; cfg changes and start mid-run ignored.
    set_cfg(2'd0, 31'h55, 8'd4, 4'd2, 4'd2);
    bus.start = 1'b1;
    sample();
    chk("t1 c0", obs(), ex(0, 0, 0, 0, 0));
    next_cyc();
    set_cfg(2'd3, 31'd0, 8'd1, 4'd0, 4'd1);
    for (int n = 1; n <= 14; n++) begin
      bus.start = (n == 4);
      sample();
      chk($sformatf("t1 c%0d", n), obs(),
          ex(0, n == 1, (n >= 2 && n <= 5) || (n >= 8 && n <= 11), n <= 12, n == 12));
      if (n == 1) begin
        chk("t1 seed", {1'b0, bus.lfsr_seed}, 32'h55);
        chk("t1 poly", {30'd0, bus.lfsr_poly}, 32'd0);
      end
      next_cyc();
    end
    bus.start = 1'b0;

    // 2: seed masking and zero substitution.
    seed_case("t2 p3 s0", 2'd3, 31'd0, 32'h0000_0001);
    seed_case("t2 p0 sF", 2'd0, 31'h7FFF_FFFF, 32'h0000_007F);
    seed_case("t2 p1 s8000", 2'd1, 31'h0000_8000, 32'h0000_0001);
    seed_case("t2 p2 sF", 2'd2, 31'h7FFF_FFFF, 32'h007F_FFFF);

    // 3: zero length is rejected.
    set_cfg(2'd0, 31'h1, 8'd0, 4'd0, 4'd1);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    sample();
    chk("t3 err", obs(), ex(1, 0, 0, 0, 0));
    next_cyc();
    sample();
    chk("t3 after", obs(), ex(0, 0, 0, 0, 0));
    next_cyc();

    // 4: continuous back-to-back bursts, stopped in cycle 20.
    set_cfg(2'd0, 31'h1, 8'd3, 4'd0, 4'd0);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      bus.stop = (n == 20);
      sample();
      chk($sformatf("t4 c%0d", n), obs(), ex(0, n == 1, n >= 2 && n <= 20, n <= 20, 0));
      next_cyc();
    end
    bus.stop = 1'b0;

    // 5: single burst of 8 with ena low in cycles 4..6.
    set_cfg(2'd1, 31'h3, 8'd8, 4'd0, 4'd1);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    steps = 0;
    for (int n = 1; n <= 15; n++) begin
      bus.ena = !(n >= 4 && n <= 6);
      sample();
      if (bus.lfsr_step) steps++;
      chk($sformatf("t5 c%0d", n), obs(),
          ex(0, n == 1, (n >= 2 && n <= 3) || (n >= 7 && n <= 12), n <= 13, n == 13));
      next_cyc();
    end
    bus.ena = 1'b1;
    chk("t5 steps", steps, 32'd8);

    // 6: reset mid-run, then a fresh run with start pulsed while busy.
    set_cfg(2'd0, 31'h55, 8'd8, 4'd0, 4'd1);
    bus.start = 1'b1;
    next_cyc();
    bus.start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      rst_n = (n != 3);
      sample();
      chk($sformatf("t6 c%0d", n), obs(), ex(0, n == 1, n >= 2, 1, 0));
      next_cyc();
    end
    rst_n = 1'b1;
    sample();
    chk("t6 post-reset", obs(), ex(0, 0, 0, 0, 0));
    chk("t6 post-reset seed", {1'b0, bus.lfsr_seed}, 32'd0);
    chk("t6 post-reset poly", {30'd0, bus.lfsr_poly}, 32'd0);
    next_cyc();
    set_cfg(2'd1, 31'h1234, 8'd2, 4'd1, 4'd2);
    bus.start = 1'b1;
    next_cyc();
    for (int m = 1; m <= 9; m++) begin
      bus.start = (m == 3);
      sample();
      chk($sformatf("t6 r%0d", m), obs(),
          ex(0, m == 1, m == 2 || m == 3 || m == 5 || m == 6, m <= 7, m == 7));
      if (m == 1) begin
        chk("t6 seed", {1'b0, bus.lfsr_seed}, 32'h1234);
        chk("t6 poly", {30'd0, bus.lfsr_poly}, 32'd1);
      end
      next_cyc();
    end
    bus.start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
